heartbeat_fader: RTL

Downstream stage of the heartbeat generator: consumes its 1-bit `heartbeat` level and drives the board LED with a PWM "breathing" fade instead of a hard on/off. A four-state sequencer ramps brightness up while the heartbeat is high and down when it drops. A free-running PWM counter renders the current brightness level onto `led_out`. The block sits between the heartbeat output register and the LED pin, in the same clock domain.

---
 rtl/heartbeat_fader.sv | 113 +++++++++++
 1 files changed

// File: rtl/heartbeat_fader.sv
// Breathing-LED fader: ramps a PWM brightness level up while the heartbeat is high and down when it drops.
// Latency: hb_q is one clock behind heartbeat_in, state one more; led_out lags level/pwm_c by one clock.
module heartbeat_fader #(
    parameter logic [26:0] CLK_FREQ = 27'd12000000,
    parameter logic [7:0]  STEP_MS  = 8'd2,
    parameter int          PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                heartbeat_in,
    output logic                led_out,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          state
);

    localparam logic [17:0]         DIVIDER   = 18'((CLK_FREQ / 27'd1000) - 27'd1);
    localparam logic [7:0]          STEP_LAST = STEP_MS - 8'd1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS-1:0] ONE       = {{(PWM_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } state_t;

    state_t              st_q;
    state_t              st_d;
    logic [PWM_BITS-1:0] lvl_d;
    logic                hb_q;
    logic [17:0]         ms_c;
    logic [7:0]          step_c;
    logic [PWM_BITS-1:0] pwm_c;
    logic                ms_p;
    logic                step_p;

    assign ms_p   = (ms_c == DIVIDER);
    assign step_p = ms_p & (step_c == STEP_LAST);
    assign state  = st_q;

    // Prescalers free-run; sequencer state changes never restart them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_q   <= 1'b0;
            ms_c   <= '0;
            step_c <= '0;
            pwm_c  <= '0;
        end else begin
            hb_q  <= heartbeat_in;
            pwm_c <= pwm_c + ONE;
            if (ms_p) begin
                ms_c   <= '0;
                step_c <= (step_c == STEP_LAST) ? 8'd0 : step_c + 8'd1;
            end else begin
                ms_c <= ms_c + 18'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            st_q    <= st_d;
            level   <= lvl_d;
            led_out <= (level == MAX) | (pwm_c < level);
        end
    end

    // A reversal takes priority over a coincident step, so level holds that cycle.
    always_comb begin
        st_d  = st_q;
        lvl_d = level;
        case (st_q)
            IDLE: begin
                lvl_d = '0;
                if (hb_q) st_d = RISE;
            end
            RISE: begin
                if (!hb_q) begin
                    st_d = FALL;
                end else if (level == MAX) begin
                    st_d = HOLD;
                end else if (step_p) begin
                    lvl_d = level + ONE;
                    if (level == MAX - ONE) st_d = HOLD;
                end
            end
            HOLD: begin
                lvl_d = MAX;
                if (!hb_q) st_d = FALL;
            end
            FALL: begin
                if (hb_q) begin
                    st_d = RISE;
                end else if (level == '0) begin
                    st_d = IDLE;
                end else if (step_p) begin
                    lvl_d = level - ONE;
                    if (level == ONE) st_d = IDLE;
                end
            end
            default: begin
                st_d  = IDLE;
                lvl_d = '0;
            end
        endcase
    end

endmodule
